// File: rtl/morse_keyer_if.sv
// Bus between the beacon control logic and morse_keyer: message buffer writes,
// transmission control, the resynchronised baud strobe and keyer status.
interface morse_keyer_if #(
  parameter int MSG_DEPTH = 32,
  parameter int ADDR_W    = $clog2(MSG_DEPTH)
);
  logic              baud_tick;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   msg_len;
  logic              start;
  logic              abort;
  logic              repeat_en;
  logic              data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] char_idx;

  modport master (
    output baud_tick, wr_en, wr_addr, wr_data, msg_len, start, abort, repeat_en,
    input  data, busy, done, char_idx
  );

  modport slave (
    input  baud_tick, wr_en, wr_addr, wr_data, msg_len, start, abort, repeat_en,
    output data, busy, done, char_idx
  );
endinterface

// File: rtl/morse_keyer.sv
// Morse message sequencer: turns an ASCII buffer into mark/space timing in baud-tick units.
// Optional message looping is compiled in with MORSE_KEYER_REPEAT_EN.
module morse_keyer #(
  parameter int MSG_DEPTH = 32,
  parameter int ADDR_W    = $clog2(MSG_DEPTH)
) (
  input logic           clk_in,
  input logic           sys_rst,
  morse_keyer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, LOOKUP, WAIT, MARK, EGAP, CGAP} state_t;

  typedef struct packed {
    logic       valid;
    logic       space;
    logic [2:0] len;
    logic [4:0] pat;   // right-aligned, first element in bit len-1, 1 = dash
  } code_t;

  function automatic code_t morse_lookup(input logic [7:0] ch);
    logic [7:0] c;
    logic [7:0] lp;
    code_t      r;
    c  = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    lp = 8'h00;
    r  = '{valid: 1'b1, space: 1'b0, len: 3'd0, pat: 5'd0};
    case (c)
      "A": lp = {3'd2, 5'b00001};  "B": lp = {3'd4, 5'b01000};
      "C": lp = {3'd4, 5'b01010};  "D": lp = {3'd3, 5'b00100};
      "E": lp = {3'd1, 5'b00000};  "F": lp = {3'd4, 5'b00010};
      "G": lp = {3'd3, 5'b00110};  "H": lp = {3'd4, 5'b00000};
      "I": lp = {3'd2, 5'b00000};  "J": lp = {3'd4, 5'b00111};
      "K": lp = {3'd3, 5'b00101};  "L": lp = {3'd4, 5'b00100};
      "M": lp = {3'd2, 5'b00011};  "N": lp = {3'd2, 5'b00010};
      "O": lp = {3'd3, 5'b00111};  "P": lp = {3'd4, 5'b00110};
      "Q": lp = {3'd4, 5'b01101};  "R": lp = {3'd3, 5'b00010};
      "S": lp = {3'd3, 5'b00000};  "T": lp = {3'd1, 5'b00001};
      "U": lp = {3'd3, 5'b00001};  "V": lp = {3'd4, 5'b00001};
      "W": lp = {3'd3, 5'b00011};  "X": lp = {3'd4, 5'b01001};
      "Y": lp = {3'd4, 5'b01011};  "Z": lp = {3'd4, 5'b01100};
      "0": lp = {3'd5, 5'b11111};  "1": lp = {3'd5, 5'b01111};
      "2": lp = {3'd5, 5'b00111};  "3": lp = {3'd5, 5'b00011};
      "4": lp = {3'd5, 5'b00001};  "5": lp = {3'd5, 5'b00000};
      "6": lp = {3'd5, 5'b10000};  "7": lp = {3'd5, 5'b11000};
      "8": lp = {3'd5, 5'b11100};  "9": lp = {3'd5, 5'b11110};
      " ": r.space = 1'b1;
      default: r.valid = 1'b0;
    endcase
    {r.len, r.pat} = lp;
    return r;
  endfunction

  state_t            state;
  logic [7:0]        mem [MSG_DEPTH];
  logic [7:0]        rd_char;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [4:0]        shreg;
  logic [2:0]        elems;
  logic [2:0]        cnt;
  logic              wrap;
  logic              data_q;
  logic              busy_q;
  logic              done_q;

  code_t code;
  logic  is_last;
  logic  start_ok;
  logic  msg_end;

  assign code     = morse_lookup(rd_char);
  assign is_last  = ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1));
  assign start_ok = (state == IDLE) && bus.start && (bus.msg_len != '0) && !bus.abort;
  assign msg_end  = (bus.baud_tick && state == MARK && cnt == 3'd1 && elems == 3'd0 && is_last)
                 || (bus.baud_tick && state == CGAP && cnt == 3'd1 && is_last && !wrap)
                 || (state == LOOKUP && !code.valid && is_last);

  assign bus.data     = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.char_idx = idx_q;

  // NOTE: the buffer has no reset; its contents deliberately survive sys_rst.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && bus.wr_en && !start_ok)
      mem[bus.wr_addr] <= bus.wr_data;
    if (state == FETCH)
      rd_char <= mem[idx_q];
  end

  // NOTE: all state below updates with <= so every branch sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state  <= IDLE;
      data_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      len_q  <= '0;
      shreg  <= '0;
      elems  <= '0;
      cnt    <= '0;
      wrap   <= 1'b0;
    end else if (bus.abort) begin
      state  <= IDLE;
      data_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      wrap   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          len_q  <= bus.msg_len;
          idx_q  <= '0;
          busy_q <= 1'b1;
          state  <= FETCH;
        end
        FETCH: state <= LOOKUP;
        LOOKUP: if (!code.valid) begin
          idx_q <= idx_q + ADDR_W'(1);
          state <= FETCH;
        end else begin
          shreg <= code.pat << (3'd5 - code.len);
          elems <= code.len;
          state <= WAIT;
        end
        // Gap counts are one unit short: the WAIT tick that starts the next
        // character supplies the final unit of every gap.
        WAIT, EGAP: if (bus.baud_tick) begin
          if (state == WAIT && code.space) begin
            cnt   <= 3'd3;
            state <= CGAP;
          end else if (state == WAIT || cnt == 3'd1) begin
            data_q <= 1'b1;
            cnt    <= shreg[4] ? 3'd3 : 3'd1;
            shreg  <= shreg << 1;
            elems  <= elems - 3'd1;
            state  <= MARK;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        MARK: if (bus.baud_tick) begin
          if (cnt == 3'd1) begin
            data_q <= 1'b0;
            if (elems != 3'd0) begin
              cnt   <= 3'd1;
              state <= EGAP;
            end else begin
              cnt   <= 3'd2;
              state <= CGAP;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        CGAP: if (bus.baud_tick) begin
          if (cnt == 3'd1) begin
            idx_q <= wrap ? '0 : idx_q + ADDR_W'(1);
            wrap  <= 1'b0;
            state <= FETCH;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (msg_end) begin
        data_q <= 1'b0;
        done_q <= 1'b1;
`ifdef MORSE_KEYER_REPEAT_EN
        if (bus.repeat_en) begin
          cnt   <= 3'd6;
          wrap  <= 1'b1;
          state <= CGAP;
        end else begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
`else
        busy_q <= 1'b0;
        state  <= IDLE;
`endif
      end
    end
  end

`ifndef MORSE_KEYER_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = bus.repeat_en;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: vector table of messages with expected
// per-tick unit strings, scoreboard queues, and hand-written abort/reset sequences.
module tb_morse_keyer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk_in = 1'b0;
  logic sys_rst;
  always #5 clk_in = ~clk_in;

  morse_keyer_if #(.MSG_DEPTH(DEPTH)) bus();
  morse_keyer #(.MSG_DEPTH(DEPTH)) dut (.clk_in(clk_in), .sys_rst(sys_rst), .bus(bus));

  typedef struct {
    string msg;
    string units;   // data level in each tick interval, from the first tick after start to done
    string idxs;    // char_idx at each mark rise
    int    passes;
  } vec_t;

  vec_t vecs[8];
  bit   unit_q[$];
  int   idx_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ph = 0;
  bit   tick_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not observed as required", name);
  endtask

  // One clock: sample point is the falling edge; baud_tick every 8 cycles.
  task automatic cycle();
    @(negedge clk_in);
    tick_prev = bus.baud_tick;
    ph = (ph + 1) % 8;
    bus.baud_tick = (ph == 0);
  endtask

  task automatic write_msg(input string msg);
    for (int i = 0; i < msg.len(); i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = msg[i];
      cycle();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic start_aligned(input int len);
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (tick_prev) break;
    end
    bus.start   = 1'b1;
    bus.msg_len = (AW+1)'(len);
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic run_msg(input string msg, input string units, input string idxs,
                         input int passes, input bit clr_rep);
    bit prev_data = 1'b0;
    bit finished  = 1'b0;
    int dones     = 0;
    write_msg(msg);
    for (int i = 0; i < units.len(); i++) unit_q.push_back(units[i] == "1");
    for (int i = 0; i < idxs.len(); i++) idx_q.push_back(int'(idxs[i]) - 48);
    start_aligned(msg.len());
    check({msg, "_busy_after_start"}, bus.busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cycle();
      // Start and a buffer write while busy must both be ignored.
      bus.start = (cyc == 20);
      bus.wr_en = (cyc == 20);
      bus.wr_addr = '0;
      bus.wr_data = "T";
      if (tick_prev) begin
        if (unit_q.size() == 0) fail_now({msg, "_unit_overrun"});
        else check({msg, "_unit"}, bus.data, unit_q.pop_front());
      end
      if (bus.data && !prev_data) begin
        if (idx_q.size() == 0) fail_now({msg, "_extra_mark"});
        else check({msg, "_char_idx"}, bus.char_idx, idx_q.pop_front());
      end
      prev_data = bus.data;
      if (bus.done) begin
        dones++;
        if (!bus.busy) begin
          finished = 1'b1;
          break;
        end else if (clr_rep) begin
          bus.repeat_en = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (!finished) fail_now({msg, "_timeout"});
    check({msg, "_units_left"}, unit_q.size(), 0);
    check({msg, "_marks_left"}, idx_q.size(), 0);
    check({msg, "_done_count"}, dones, passes);
    unit_q.delete();
    idx_q.delete();
    cycle();
    check({msg, "_done_one_cycle"}, bus.done, 0);
    check({msg, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    bit saw_done;
    vecs[0] = '{"E",   "10",                           "0",         1};
    vecs[1] = '{"SOS", "1010100011101110111000101010", "000111222", 1};
    vecs[2] = '{"A B", "1011100000001110101010",       "002222",    1};
    vecs[3] = '{"#E",  "10",                           "1",         1};
    vecs[4] = '{" E",  "000010",                       "1",         1};
    vecs[5] = '{"e5",  "10001010101010",               "011111",    1};
    vecs[6] = '{"K",   "1110101110",                   "000",       1};
    vecs[7] = '{"T",   "1110",                         "0",         1};

    sys_rst = 1'b1;
    bus.baud_tick = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.msg_len = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0;
    repeat (3) cycle();
    sys_rst = 1'b0;
    cycle();
    check("rst_data", bus.data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_char_idx", bus.char_idx, 0);

    for (int v = 0; v < 7; v++)
      run_msg(vecs[v].msg, vecs[v].units, vecs[v].idxs, vecs[v].passes, 1'b0);

    // Zero-length start, then start together with abort: both ignored.
    bus.msg_len = '0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    check("len0_busy", bus.busy, 0);
    bus.msg_len = 1; bus.start = 1'b1; bus.abort = 1'b1;
    cycle();
    bus.start = 1'b0; bus.abort = 1'b0;
    cycle();
    check("start_abort_busy", bus.busy, 0);

    // Abort one tick into the dash of "T".
    write_msg("T");
    start_aligned(1);
    for (int i = 0; i < 9; i++) begin cycle(); if (tick_prev) break; end
    check("abort_pre_mark", bus.data, 1);
    for (int i = 0; i < 9; i++) begin cycle(); if (tick_prev) break; end
    cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    check("abort_data", bus.data, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_char_idx", bus.char_idx, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin cycle(); if (bus.done) saw_done = 1'b1; end
    check("abort_no_done", saw_done, 0);
    run_msg(vecs[7].msg, vecs[7].units, vecs[7].idxs, vecs[7].passes, 1'b0);

    // Mid-operation reset.
    start_aligned(1);
    for (int i = 0; i < 9; i++) begin cycle(); if (tick_prev) break; end
    check("midrst_pre_mark", bus.data, 1);
    sys_rst = 1'b1;
    cycle();
    sys_rst = 1'b0;
    check("midrst_data", bus.data, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (20) cycle();
    check("midrst_stays_idle", bus.busy, 0);

    // Looping: repeat_en cleared at the first done, so exactly two passes.
    bus.repeat_en = 1'b1;
`ifdef MORSE_KEYER_REPEAT_EN
    run_msg("E", "1000000010", "00", 2, 1'b1);
`else
    run_msg("E", "10", "0", 1, 1'b1);
`endif
    bus.repeat_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Message sequencer that drives the `data` (mark/space) input of the CPFSK modulator.
- Holds an ASCII message buffer and converts each character to International Morse timing, in units of one baud tick.
- Emits a registered mark/space bit plus busy/done status.
- Sits between the beacon control logic and the modulator. Runs on `clk_in` and consumes the modulator's baud strobe, resynchronised to `clk_in` as a one-cycle `baud_tick`.

Parameters:
- MSG_DEPTH, 32, message buffer entries (power of two, 2..256).
- ADDR_W, $clog2(MSG_DEPTH), buffer address width (derived; do not override).

Ports:
- clk_in  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-cycle strobe; one Morse unit per tick; minimum spacing 4 clk_in cycles.
- wr_en  in  1  buffer write strobe; ignored while busy.
- wr_addr  in  ADDR_W  buffer write address.
- wr_data  in  8  ASCII character.
- msg_len  in  ADDR_W+1  number of characters; sampled at start.
- start  in  1  begin transmission; honoured only in IDLE with msg_len != 0.
- abort  in  1  stop immediately.
- repeat_en  in  1  loop message (used only with the optional feature).
- data  out  1  1 = mark (key down), 0 = space; registered.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- char_idx  out  ADDR_W  index of the character being sent.

Behaviour:
- Clock and reset: one clock, clk_in. sys_rst is synchronous, active-high.
- Reset values: data=0, busy=0, done=0, char_idx=0, state=IDLE. Buffer contents are not cleared.
- Morse unit timing: dot=1, dash=3, intra-character gap=1, inter-character gap=3, word gap=7.
- Character table (combinational): A-Z, a-z folded to upper case, 0-9, and space. Each entry is a length 1..5 plus a pattern, MSB-first, 1=dash.
- Unknown codes are skipped: zero units, no extra gap.
- Space inserts 4 units of space, extending the preceding 3-unit gap to 7. A leading space gives 4 units of silence.
- IDLE: on start && msg_len!=0, latch msg_len, set char_idx=0, busy=1 next cycle, go to FETCH. start with msg_len=0 is ignored.
- FETCH (1 cycle): registered buffer read at char_idx.
- LOOKUP (1 cycle): load pattern and length; go to WAIT.
  - Unknown character: advance char_idx (or finish if last) and go back to FETCH without consuming ticks.
- WAIT: on the next baud_tick, start the first element.
  - data=1 (space character: data stays 0); visible the cycle after the tick.
  - Unit counter loaded with element length (1 or 3; space: 4). Go to MARK (space: CGAP).
- MARK: decrement on each tick. On the tick where the counter expires, data=0, then:
  - more elements in character: EGAP with count 1;
  - else more characters: CGAP with count 3;
  - else: finish.
- EGAP: on expiry tick, start the next element (data=1, same tick).
- CGAP: on expiry tick, advance char_idx and go to FETCH.
  - Fetch/lookup complete before the next tick because of the 4-cycle minimum tick spacing.
  - The next element starts on the following tick.
- Element boundary: a mark lasts exactly N tick intervals (rises on tick k, falls on tick k+N).
- Finish: data=0, done=1 for one cycle, busy=0 on the same cycle, state=IDLE. No trailing gap.
- abort (any state, priority below sys_rst): next cycle data=0, busy=0, state=IDLE, char_idx=0; no done pulse.
- Simultaneous start and abort in IDLE: abort wins; start is ignored.
- Writes: occur in IDLE only; a write on the same cycle as an accepted start is ignored.
- start while busy is ignored.
- Mid-operation sys_rst behaves exactly as reset.

Optional Feature:
- Macro: MORSE_KEYER_REPEAT_EN.
- Defined: at message end with repeat_en=1, insert a 7-unit space gap, reset char_idx=0, continue from FETCH. Pulse done once per pass on the final-mark fall tick; busy stays high. Deassert repeat_en to finish normally at the next message end; abort stops at any time.
- Undefined: repeat_en is ignored; the port exists but is unconnected internally.

Test Plan:
- Write "E", msg_len=1, start, ticks every 8 cycles -> data high exactly 1 tick interval; done one cycle after the fall-tick; busy low afterwards.
- "SOS" -> data unit sequence 1010100011101110111000101010 (28 units), then done; char_idx steps 0,1,2.
- "A B" -> 10111 followed by 7 space units, then 1110101010; total 22 units.
- "T" with abort asserted 1 tick into the dash -> data=0 and busy=0 the next cycle, no done; a subsequent start replays the full dash.
- msg_len=0 start -> busy stays 0; start+abort same cycle -> ignored; "#E" -> identical waveform to "E".
- With MORSE_KEYER_REPEAT_EN, "E", repeat_en=1 -> dot, 7 space units, dot, ...; done pulses each pass; clear repeat_en -> stops after the current pass.
